dp_seq_core: RTL and testbench

//  Multi-cycle, parametrised successor of our single-cycle datapath.
//  - Contains the register file, ALU, branch/PC unit and an external data-memory port with a req/ack handshake.
//  - Accepts one decoded instruction per valid/ready issue handshake from the control unit.
//  - Sits between the control unit and the data RAM; supports memory-wait stalls.

---
 rtl/dp_seq_core_if.sv | 23 ++
 rtl/dp_seq_core.sv | 227 ++++++++++++++++++++++
 tb/tb_dp_seq_core.sv | 329 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dp_seq_core_if.sv
// Data-memory port of dp_seq_core: req/ack handshake.
// The master (core) holds req/we/addr/wdata stable until the slave (RAM) returns ack.
interface dp_seq_core_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 10
);
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_ack, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_ack, mem_rdata
  );
endinterface

// File: rtl/dp_seq_core.sv
// Multi-cycle datapath: register file, ALU, PC unit and a req/ack data-memory port.
// One decoded instruction is accepted per issue handshake (only while IDLE).
// Optional macro DP_DIV_EN enables unsigned divide/modulo on ALU codes 4/5;
// without it those codes behave like any illegal code (all-ones result, err set).
module dp_seq_core #(
  parameter int  DATA_W = 32,
  parameter int  NREGS  = 8,
  parameter int  IMM_W  = 21,
  parameter int  ADDR_W = 10,
  parameter int  PC_W   = 32,
  localparam int RIDX_W = $clog2(NREGS)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              iss_valid,
  output logic              iss_ready,
  input  logic [4:0]        alucode,
  input  logic [RIDX_W-1:0] op1,
  input  logic [IMM_W-1:0]  op2,
  input  logic              imControl,
  input  logic              flag,
  input  logic              flag1,
  input  logic [3:0]        pcControl,
  input  logic              writecode,
  dp_seq_core_if.master     mem,
  output logic [PC_W-1:0]   PC,
  output logic [DATA_W-1:0] result,
  output logic              done,
  output logic              err
);

  typedef enum logic [2:0] {IDLE, RDA, RDB, EXEC, WRM} state_t;

  state_t state, state_n;

  logic [DATA_W-1:0] regs [NREGS];

  logic [4:0]        alucode_q;
  logic [RIDX_W-1:0] op1_q;
  logic [IMM_W-1:0]  op2_q;
  logic              imm_q, flag_q, flag1_q, wcode_q;
  logic [3:0]        pcc_q;
  logic [DATA_W-1:0] a_mem, b_mem;

  logic [RIDX_W-1:0] srcb, jreg;
  logic              need_b_mem;
  logic [DATA_W-1:0] a_val, b_val, alu_res, towrite;
  logic              alu_bad, pc_bad, taken;
  logic [PC_W-1:0]   pc_next;

  assign srcb       = op2_q[RIDX_W-1:0];
  assign jreg       = op2_q[2*RIDX_W-1:RIDX_W];
  assign need_b_mem = flag1_q && !imm_q;
  assign a_val      = flag_q ? a_mem : regs[op1_q];
  assign b_val      = imm_q ? {{(DATA_W-IMM_W){op2_q[IMM_W-1]}}, op2_q}
                            : (flag1_q ? b_mem : regs[srcb]);
  // In WRM the ALU result has already been registered, so the write-back value comes from it.
  assign towrite    = wcode_q ? b_val : ((state == WRM) ? result : alu_res);

  // ALU: unsigned wrapping arithmetic; unknown codes flag an error and return all-ones
  always_comb begin
    alu_res = '0;
    alu_bad = 1'b0;
    case (alucode_q)
      5'd0:  alu_res = a_val;
      5'd1:  alu_res = a_val + b_val;
      5'd2:  alu_res = a_val - b_val;
      5'd3:  alu_res = a_val * b_val;
`ifdef DP_DIV_EN
      5'd4: begin
        if (b_val == '0) begin
          alu_res = '1;
          alu_bad = 1'b1;
        end else begin
          alu_res = a_val / b_val;
        end
      end
      5'd5: begin
        if (b_val == '0) begin
          alu_res = '1;
          alu_bad = 1'b1;
        end else begin
          alu_res = a_val % b_val;
        end
      end
`endif
      5'd6:  alu_res = a_val | b_val;
      5'd7:  alu_res = a_val & b_val;
      5'd8:  alu_res = a_val ^ b_val;
      5'd9:  alu_res = ~a_val;
      5'd10: alu_res = a_val >> 1;
      5'd11: alu_res = a_val << 1;
      5'd12: alu_res = $signed(a_val) >>> 1;
      default: begin
        alu_res = '1;
        alu_bad = 1'b1;
      end
    endcase
  end

  // Branch unit: unsigned compares of A/B pick between PC+regs[jreg], PC+1 and hold
  always_comb begin
    taken   = 1'b0;
    pc_bad  = 1'b0;
    pc_next = PC + PC_W'(1);
    case (pcc_q)
      4'd0:    taken = 1'b0;
      4'd1:    taken = (a_val == b_val);
      4'd2:    taken = (a_val <  b_val);
      4'd3:    taken = (a_val >  b_val);
      4'd4:    taken = (a_val != b_val);
      4'd5:    taken = (a_val <= b_val);
      4'd6:    taken = (a_val >= b_val);
      4'd7:    taken = (a_val != '0);
      4'd8:    taken = (a_val == '0);
      4'd9:    taken = 1'b1;
      4'd10:   taken = 1'b0;
      default: pc_bad = 1'b1;
    endcase
    if (taken) begin
      pc_next = PC + PC_W'(regs[jreg]);
    end else if (pcc_q == 4'd10) begin
      pc_next = PC;
    end
  end

  // FSM state register
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  // FSM next state plus issue-ready and memory request outputs
  always_comb begin
    state_n       = state;
    iss_ready     = 1'b0;
    mem.mem_req   = 1'b0;
    mem.mem_we    = 1'b0;
    mem.mem_addr  = '0;
    mem.mem_wdata = '0;
    case (state)
      IDLE: begin
        iss_ready = 1'b1;
        if (iss_valid) begin
          if (flag)                   state_n = RDA;
          else if (flag1 && !imControl) state_n = RDB;
          else                        state_n = EXEC;
        end
      end
      RDA: begin
        mem.mem_req  = 1'b1;
        mem.mem_addr = regs[op1_q][ADDR_W-1:0];
        if (mem.mem_ack) state_n = need_b_mem ? RDB : EXEC;
      end
      RDB: begin
        mem.mem_req  = 1'b1;
        mem.mem_addr = regs[srcb][ADDR_W-1:0];
        if (mem.mem_ack) state_n = EXEC;
      end
      EXEC: begin
        state_n = flag_q ? WRM : IDLE;
      end
      WRM: begin
        mem.mem_req   = 1'b1;
        mem.mem_we    = 1'b1;
        mem.mem_addr  = regs[op1_q][ADDR_W-1:0];
        mem.mem_wdata = towrite;
        if (mem.mem_ack) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Datapath state: field capture, memory operand latches, execute/retire updates
  always_ff @(posedge clock) begin
    if (reset) begin
      PC        <= '0;
      result    <= '0;
      done      <= 1'b0;
      err       <= 1'b0;
      alucode_q <= '0;
      op1_q     <= '0;
      op2_q     <= '0;
      imm_q     <= 1'b0;
      flag_q    <= 1'b0;
      flag1_q   <= 1'b0;
      wcode_q   <= 1'b0;
      pcc_q     <= '0;
      a_mem     <= '0;
      b_mem     <= '0;
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (iss_valid) begin
            alucode_q <= alucode;
            op1_q     <= op1;
            op2_q     <= op2;
            imm_q     <= imControl;
            flag_q    <= flag;
            flag1_q   <= flag1;
            wcode_q   <= writecode;
            pcc_q     <= pcControl;
          end
        end
        RDA: if (mem.mem_ack) a_mem <= mem.mem_rdata;
        RDB: if (mem.mem_ack) b_mem <= mem.mem_rdata;
        EXEC: begin
          result <= alu_res;
          PC     <= pc_next;
          if (alu_bad || pc_bad) err <= 1'b1;
          if (!flag_q) begin
            regs[op1_q] <= towrite;
            done        <= 1'b1;
          end
        end
        WRM: if (mem.mem_ack) done <= 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dp_seq_core.sv
// Self-checking bench for dp_seq_core: directed scenarios plus randomized instructions
// checked against an instruction-level reference model and a bench-side RAM with random wait states.
module tb_dp_seq_core;
  localparam int DATA_W = 32;
  localparam int NREGS  = 8;
  localparam int IMM_W  = 21;
  localparam int ADDR_W = 10;
  localparam int PC_W   = 32;

  logic              clock = 1'b0;
  logic              reset;
  logic              iss_valid;
  logic              iss_ready;
  logic [4:0]        alucode;
  logic [2:0]        op1;
  logic [IMM_W-1:0]  op2;
  logic              imControl, flag, flag1, writecode;
  logic [3:0]        pcControl;
  logic [PC_W-1:0]   PC;
  logic [DATA_W-1:0] result;
  logic              done, err;

  dp_seq_core_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) mem_bus ();

  dp_seq_core #(
    .DATA_W(DATA_W), .NREGS(NREGS), .IMM_W(IMM_W), .ADDR_W(ADDR_W), .PC_W(PC_W)
  ) dut (
    .clock(clock), .reset(reset),
    .iss_valid(iss_valid), .iss_ready(iss_ready),
    .alucode(alucode), .op1(op1), .op2(op2),
    .imControl(imControl), .flag(flag), .flag1(flag1),
    .pcControl(pcControl), .writecode(writecode),
    .mem(mem_bus),
    .PC(PC), .result(result), .done(done), .err(err)
  );

  always #5 clock = ~clock;

  int tests = 0;
  int fails = 0;

  logic [DATA_W-1:0] mregs [NREGS];
  logic [DATA_W-1:0] ram [1 << ADDR_W];
  logic [PC_W-1:0]   mpc;
  logic              merr;

  typedef struct {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } acc_t;

  acc_t expAcc[$];

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [DATA_W-1:0] sext(input logic [IMM_W-1:0] v);
    return DATA_W'($signed(v));
  endfunction

  function automatic logic [DATA_W-1:0] aluModel(input logic [4:0] code, input logic [DATA_W-1:0] a,
                                                 input logic [DATA_W-1:0] b, output logic bad);
    logic [DATA_W-1:0] r;
    bad = 1'b0;
    r   = '1;
    case (code)
      5'd0:  r = a;
      5'd1:  r = a + b;
      5'd2:  r = a - b;
      5'd3:  r = a * b;
`ifdef DP_DIV_EN
      5'd4:  if (b != 0) r = a / b; else bad = 1'b1;
      5'd5:  if (b != 0) r = a % b; else bad = 1'b1;
`endif
      5'd6:  r = a | b;
      5'd7:  r = a & b;
      5'd8:  r = a ^ b;
      5'd9:  r = ~a;
      5'd10: r = a / 2;
      5'd11: r = a * 2;
      5'd12: r = (a / 2) | (a & 32'h8000_0000);
      default: bad = 1'b1;
    endcase
    return r;
  endfunction

  task automatic resetDut();
    reset = 1'b1;
    iss_valid = 1'b0; alucode = '0; op1 = '0; op2 = '0;
    imControl = 1'b0; flag = 1'b0; flag1 = 1'b0; pcControl = '0; writecode = 1'b0;
    mem_bus.mem_ack = 1'b0; mem_bus.mem_rdata = '0;
    @(posedge clock);
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    for (int i = 0; i < NREGS; i++) mregs[i] = '0;
    mpc  = '0;
    merr = 1'b0;
  endtask

  // Issue one instruction, act as RAM with waits in [minW,maxW], then compare against the model.
  task automatic applyStimulus(input logic [4:0] code, input logic [2:0] o1, input logic [IMM_W-1:0] o2,
                               input logic imm, input logic f, input logic f1, input logic [3:0] pcc,
                               input logic wc, input int minW, input int maxW);
    logic [DATA_W-1:0] a, b, res, tw;
    logic [ADDR_W-1:0] addrA, addrB;
    logic              bad, pcBad, tk;
    logic [PC_W-1:0]   npc;
    int                lat, expLat, waitLeft;
    bit                inAccess, finished;
    acc_t              acc;

    addrA = mregs[o1][ADDR_W-1:0];
    addrB = mregs[o2[2:0]][ADDR_W-1:0];
    a     = f ? ram[addrA] : mregs[o1];
    b     = imm ? sext(o2) : (f1 ? ram[addrB] : mregs[o2[2:0]]);
    res   = aluModel(code, a, b, bad);
    tw    = wc ? b : res;
    pcBad = 1'b0;
    tk    = 1'b0;
    case (pcc)
      4'd1: tk = a == b;
      4'd2: tk = a < b;
      4'd3: tk = a > b;
      4'd4: tk = a != b;
      4'd5: tk = a <= b;
      4'd6: tk = a >= b;
      4'd7: tk = a != 0;
      4'd8: tk = a == 0;
      4'd9: tk = 1'b1;
      4'd0, 4'd10: tk = 1'b0;
      default: pcBad = 1'b1;
    endcase
    npc = tk ? mpc + mregs[o2[5:3]] : ((pcc == 4'd10) ? mpc : mpc + 1);

    expAcc.delete();
    if (f) expAcc.push_back('{we: 1'b0, addr: addrA, wdata: '0});
    if (f1 && !imm) expAcc.push_back('{we: 1'b0, addr: addrB, wdata: '0});
    if (f) expAcc.push_back('{we: 1'b1, addr: addrA, wdata: tw});

    checkOutput("iss_ready", iss_ready, 1);
    alucode = code; op1 = o1; op2 = o2; imControl = imm; flag = f; flag1 = f1;
    pcControl = pcc; writecode = wc; iss_valid = 1'b1;
    @(posedge clock);
    lat = 1; expLat = 2; inAccess = 0; finished = 0; waitLeft = 0;
    for (int cyc = 0; cyc < 300; cyc++) begin
      @(negedge clock);
      if (done) begin
        finished = 1;
        break;
      end
      iss_valid = 1'b1;
      alucode = 5'($urandom); op1 = 3'($urandom); op2 = IMM_W'($urandom);
      imControl = 1'($urandom); flag = 1'($urandom); flag1 = 1'($urandom);
      pcControl = 4'($urandom); writecode = 1'($urandom);
      if (mem_bus.mem_req) begin
        if (!inAccess) begin
          inAccess = 1;
          waitLeft = $urandom_range(maxW, minW);
          expLat += 1 + waitLeft;
        end
        if (waitLeft == 0) begin
          mem_bus.mem_ack = 1'b1;
          inAccess = 0;
          if (expAcc.size() == 0) begin
            checkOutput("mem_extra_access", 1, 0);
          end else begin
            acc = expAcc.pop_front();
            checkOutput("mem_we", mem_bus.mem_we, acc.we);
            checkOutput("mem_addr", mem_bus.mem_addr, acc.addr);
            if (acc.we) begin
              checkOutput("mem_wdata", mem_bus.mem_wdata, acc.wdata);
              ram[mem_bus.mem_addr] = mem_bus.mem_wdata;
            end else begin
              mem_bus.mem_rdata = ram[mem_bus.mem_addr];
            end
          end
        end else begin
          mem_bus.mem_ack   = 1'b0;
          mem_bus.mem_rdata = $urandom;
          waitLeft--;
        end
      end else begin
        mem_bus.mem_ack   = 1'($urandom);
        mem_bus.mem_rdata = $urandom;
      end
      @(posedge clock);
      lat++;
    end
    iss_valid = 1'b0;
    mem_bus.mem_ack = 1'b0;
    if (!finished) checkOutput("done_timeout", 0, 1);

    if (!f) mregs[o1] = tw;
    mpc  = npc;
    merr = merr | bad | pcBad;
    checkOutput("latency", lat, expLat);
    checkOutput("result", result, res);
    checkOutput("PC", PC, mpc);
    checkOutput("err", err, merr);
    checkOutput("mem_pending", expAcc.size(), 0);
    @(posedge clock);
    @(negedge clock);
    checkOutput("done_pulse", done, 0);
  endtask

  initial begin
    logic [4:0] c;
    for (int i = 0; i < (1 << ADDR_W); i++) ram[i] = $urandom;

    resetDut();
    checkOutput("rst_PC", PC, 0);
    checkOutput("rst_result", result, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_err", err, 0);
    checkOutput("rst_iss_ready", iss_ready, 1);
    checkOutput("rst_mem_req", mem_bus.mem_req, 0);
    checkOutput("rst_mem_addr", mem_bus.mem_addr, 0);
    checkOutput("rst_mem_wdata", mem_bus.mem_wdata, 0);

    // Immediate add into a cleared register
    applyStimulus(5'd1, 3'd2, 21'd5, 1, 0, 0, 4'd0, 0, 0, 0);
    checkOutput("t1_result", result, 5);
    checkOutput("t1_PC", PC, 1);
    applyStimulus(5'd0, 3'd2, 21'd0, 0, 0, 0, 4'd0, 0, 0, 0);
    checkOutput("t1_reg2", result, 5);

    // Sign-extended immediate of -1
    applyStimulus(5'd0, 3'd3, 21'd3, 1, 0, 0, 4'd0, 1, 0, 0);
    applyStimulus(5'd1, 3'd3, 21'h1FFFFF, 1, 0, 0, 4'd0, 0, 0, 0);
    checkOutput("t2_result", result, 2);

    // Memory read-modify-write with 3 wait cycles per access
    applyStimulus(5'd0, 3'd1, 21'h10, 1, 0, 0, 4'd0, 1, 0, 0);
    ram[16] = 32'd7;
    applyStimulus(5'd11, 3'd1, 21'd0, 0, 1, 0, 4'd0, 0, 3, 3);
    checkOutput("t3_ram", ram[16], 14);
    checkOutput("t3_result", result, 14);

    // Randomized instruction stream (legal ALU and PC codes only)
    for (int n = 0; n < 80; n++) begin
      c = 5'($urandom_range(10, 0));
      if (c >= 5'd4) c = c + 5'd2;
      applyStimulus(c, 3'($urandom), IMM_W'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                    4'($urandom_range(10, 0)), 1'($urandom), 0, 3);
    end
    for (int k = 0; k < NREGS; k++) begin
      applyStimulus(5'd0, 3'(k), 21'd0, 0, 0, 0, 4'd0, 0, 0, 0);
      checkOutput("readback", result, mregs[k]);
    end

    // Branch: PC=10, A=3 < B=4 taken by regs[jreg]=-2; then A=5 not taken
    resetDut();
    applyStimulus(5'd0, 3'd1, 21'd3, 1, 0, 0, 4'd0, 1, 0, 0);
    applyStimulus(5'd0, 3'd2, 21'd4, 1, 0, 0, 4'd0, 1, 0, 0);
    applyStimulus(5'd0, 3'd5, 21'h1FFFFE, 1, 0, 0, 4'd0, 1, 0, 0);
    applyStimulus(5'd0, 3'd7, 21'd5, 1, 0, 0, 4'd0, 1, 0, 0);
    applyStimulus(5'd0, 3'd6, 21'd5, 1, 0, 0, 4'd0, 1, 0, 0);
    applyStimulus(5'd0, 3'd0, 21'd48, 0, 0, 0, 4'd9, 0, 0, 0);
    checkOutput("t4_PC10", PC, 10);
    applyStimulus(5'd0, 3'd1, 21'd42, 0, 0, 0, 4'd2, 0, 0, 0);
    checkOutput("t4_taken", PC, 8);
    applyStimulus(5'd0, 3'd7, 21'd42, 0, 0, 0, 4'd2, 0, 0, 0);
    checkOutput("t4_not_taken", PC, 9);

    // Divide / modulo
    resetDut();
    applyStimulus(5'd0, 3'd1, 21'd17, 1, 0, 0, 4'd0, 1, 0, 0);
    applyStimulus(5'd4, 3'd1, 21'd5, 1, 0, 0, 4'd0, 0, 0, 0);
`ifdef DP_DIV_EN
    checkOutput("t5_div", result, 3);
    checkOutput("t5_div_err", err, 0);
`else
    checkOutput("t5_nodiv_result", result, 32'hFFFF_FFFF);
    checkOutput("t5_nodiv_err", err, 1);
`endif
    applyStimulus(5'd5, 3'd1, 21'd5, 1, 0, 0, 4'd0, 0, 0, 0);
    applyStimulus(5'd4, 3'd1, 21'd0, 1, 0, 0, 4'd0, 0, 0, 0);
    checkOutput("t5_div0_result", result, 32'hFFFF_FFFF);
    checkOutput("t5_div0_err", err, 1);

    // Illegal ALU code and illegal PC mode
    resetDut();
    applyStimulus(5'd13, 3'd0, 21'd0, 0, 0, 0, 4'd0, 0, 0, 0);
    checkOutput("bad_alu_err", err, 1);
    resetDut();
    applyStimulus(5'd1, 3'd0, 21'd1, 1, 0, 0, 4'd12, 0, 0, 0);
    checkOutput("bad_pc_err", err, 1);
    checkOutput("bad_pc_PC", PC, 1);

    // Reset while RDA waits for ack; a late ack must be ignored
    resetDut();
    applyStimulus(5'd0, 3'd1, 21'h10, 1, 0, 0, 4'd0, 1, 0, 0);
    alucode = 5'd11; op1 = 3'd1; op2 = '0; imControl = 1'b0; flag = 1'b1; flag1 = 1'b0;
    pcControl = 4'd0; writecode = 1'b0; iss_valid = 1'b1; mem_bus.mem_ack = 1'b0;
    @(posedge clock);
    @(negedge clock);
    iss_valid = 1'b0;
    checkOutput("t6_req_pending", mem_bus.mem_req, 1);
    checkOutput("t6_addr_pending", mem_bus.mem_addr, 16);
    reset = 1'b1;
    @(posedge clock);
    @(negedge clock);
    checkOutput("t6_req", mem_bus.mem_req, 0);
    checkOutput("t6_ready", iss_ready, 1);
    checkOutput("t6_PC", PC, 0);
    reset = 1'b0;
    mem_bus.mem_ack = 1'b1;
    mem_bus.mem_rdata = $urandom;
    @(posedge clock);
    @(negedge clock);
    mem_bus.mem_ack = 1'b0;
    checkOutput("t6_late_ready", iss_ready, 1);
    checkOutput("t6_late_req", mem_bus.mem_req, 0);
    checkOutput("t6_late_done", done, 0);
    checkOutput("t6_late_PC", PC, 0);
    checkOutput("t6_late_result", result, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
